// File: rtl/alu_issue_pkg.sv
// Shared definitions for the ALU issue stage: MIPS opcode/funct codes,
// one-hot ALU control bit positions and the decoded payload record.
package alu_issue_pkg;

    localparam int DATA_W = 32;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    localparam int ALU_CTRL_ADD  = 11;
    localparam int ALU_CTRL_SUB  = 10;
    localparam int ALU_CTRL_SLT  = 9;
    localparam int ALU_CTRL_SLTU = 8;
    localparam int ALU_CTRL_AND  = 7;
    localparam int ALU_CTRL_NOR  = 6;
    localparam int ALU_CTRL_OR   = 5;
    localparam int ALU_CTRL_XOR  = 4;
    localparam int ALU_CTRL_SLL  = 3;
    localparam int ALU_CTRL_SRL  = 2;
    localparam int ALU_CTRL_SRA  = 1;
    localparam int ALU_CTRL_LUI  = 0;

    typedef struct packed {
        logic [11:0]       alu_control;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [4:0]        dest;
        logic              ov_en;
        logic              ri;
    } alu_payload_t;

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational decoder: instruction word plus register operands to the
// ALU payload (one-hot control, operands, destination, trap enable).
module alu_issue_dec
    import alu_issue_pkg::*;
(
    input  logic [31:0]  inst,
    input  logic [31:0]  rs_val,
    input  logic [31:0]  rt_val,
    output alu_payload_t payload
);

    logic [5:0]   op_s;
    logic [5:0]   funct_s;
    logic [31:0]  sext_s;
    logic [31:0]  zext_s;
    logic         unused_rs_s;
    alu_payload_t dec_s;

    assign op_s        = inst[31:26];
    assign funct_s     = inst[5:0];
    assign sext_s      = {{16{inst[15]}}, inst[15:0]};
    assign zext_s      = {16'h0000, inst[15:0]};
    // The rs field is already resolved into rs_val upstream.
    assign unused_rs_s = ^inst[25:21];

    // Opcode/funct decode; unsupported encodings fall back to raw operands with ri set.
    always_comb begin
        dec_s       = '0;
        dec_s.src1  = rs_val;
        dec_s.src2  = rt_val;
        case (op_s)
            OP_SPECIAL: begin
                dec_s.dest = inst[15:11];
                case (funct_s)
                    FN_ADD:  begin dec_s.alu_control[ALU_CTRL_ADD] = 1'b1; dec_s.ov_en = 1'b1; end
                    FN_ADDU: dec_s.alu_control[ALU_CTRL_ADD] = 1'b1;
                    FN_SUB:  begin dec_s.alu_control[ALU_CTRL_SUB] = 1'b1; dec_s.ov_en = 1'b1; end
                    FN_SUBU: dec_s.alu_control[ALU_CTRL_SUB]  = 1'b1;
                    FN_SLT:  dec_s.alu_control[ALU_CTRL_SLT]  = 1'b1;
                    FN_SLTU: dec_s.alu_control[ALU_CTRL_SLTU] = 1'b1;
                    FN_AND:  dec_s.alu_control[ALU_CTRL_AND]  = 1'b1;
                    FN_OR:   dec_s.alu_control[ALU_CTRL_OR]   = 1'b1;
                    FN_XOR:  dec_s.alu_control[ALU_CTRL_XOR]  = 1'b1;
                    FN_NOR:  dec_s.alu_control[ALU_CTRL_NOR]  = 1'b1;
                    FN_SLL:  begin dec_s.alu_control[ALU_CTRL_SLL] = 1'b1; dec_s.src1 = {27'd0, inst[10:6]}; end
                    FN_SRL:  begin dec_s.alu_control[ALU_CTRL_SRL] = 1'b1; dec_s.src1 = {27'd0, inst[10:6]}; end
                    FN_SRA:  begin dec_s.alu_control[ALU_CTRL_SRA] = 1'b1; dec_s.src1 = {27'd0, inst[10:6]}; end
                    FN_SLLV: dec_s.alu_control[ALU_CTRL_SLL]  = 1'b1;
                    FN_SRLV: dec_s.alu_control[ALU_CTRL_SRL]  = 1'b1;
                    FN_SRAV: dec_s.alu_control[ALU_CTRL_SRA]  = 1'b1;
                    default: begin dec_s.ri = 1'b1; dec_s.dest = 5'd0; end
                endcase
            end
            OP_ADDI:  begin
                dec_s.alu_control[ALU_CTRL_ADD] = 1'b1; dec_s.ov_en = 1'b1;
                dec_s.src2 = sext_s; dec_s.dest = inst[20:16];
            end
            OP_ADDIU: begin dec_s.alu_control[ALU_CTRL_ADD]  = 1'b1; dec_s.src2 = sext_s; dec_s.dest = inst[20:16]; end
            OP_SLTI:  begin dec_s.alu_control[ALU_CTRL_SLT]  = 1'b1; dec_s.src2 = sext_s; dec_s.dest = inst[20:16]; end
            OP_SLTIU: begin dec_s.alu_control[ALU_CTRL_SLTU] = 1'b1; dec_s.src2 = sext_s; dec_s.dest = inst[20:16]; end
            OP_ANDI:  begin dec_s.alu_control[ALU_CTRL_AND]  = 1'b1; dec_s.src2 = zext_s; dec_s.dest = inst[20:16]; end
            OP_ORI:   begin dec_s.alu_control[ALU_CTRL_OR]   = 1'b1; dec_s.src2 = zext_s; dec_s.dest = inst[20:16]; end
            OP_XORI:  begin dec_s.alu_control[ALU_CTRL_XOR]  = 1'b1; dec_s.src2 = zext_s; dec_s.dest = inst[20:16]; end
            OP_LUI:   begin
                dec_s.alu_control[ALU_CTRL_LUI] = 1'b1;
                dec_s.src1 = 32'h0000_0000; dec_s.src2 = zext_s; dec_s.dest = inst[20:16];
            end
            default:  dec_s.ri = 1'b1;
        endcase
    end

    assign payload = dec_s;

endmodule

// File: rtl/alu_issue_stage.sv
// ID->EXE issue stage: decodes ALU instructions and registers them behind a
// valid/ready handshake. Define ALU_ISSUE_SKID_EN for a 2-entry skid buffer.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [DATA_W-1:0] in_rs_val,
    input  logic [DATA_W-1:0] in_rt_val,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [11:0]       out_alu_control,
    output logic [DATA_W-1:0] out_alu_src1,
    output logic [DATA_W-1:0] out_alu_src2,
    output logic [4:0]        out_dest,
    output logic              out_ov_en,
    output logic              out_ri
);

    alu_payload_t dec_s;
    alu_payload_t main_r;
    logic         main_valid_r;
    logic         in_fire_s;
    logic         out_fire_s;

    alu_issue_dec u_dec (
        .inst    (in_inst),
        .rs_val  (in_rs_val),
        .rt_val  (in_rt_val),
        .payload (dec_s)
    );

    assign out_fire_s = main_valid_r & out_ready;
    assign in_fire_s  = in_valid & in_ready;

`ifdef ALU_ISSUE_SKID_EN
    alu_payload_t skid_r;
    logic         skid_valid_r;

    assign in_ready = ~skid_valid_r;

    // Main/skid registers: skid parks one entry while EXE stalls, refills main on departure.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
            main_r       <= '0;
            skid_r       <= '0;
        end else if (flush) begin
            main_valid_r <= 1'b0;
            skid_valid_r <= 1'b0;
        end else if (~main_valid_r | out_fire_s) begin
            if (skid_valid_r) begin
                main_r       <= skid_r;
                main_valid_r <= 1'b1;
                skid_valid_r <= 1'b0;
            end else if (in_fire_s) begin
                main_r       <= dec_s;
                main_valid_r <= 1'b1;
            end else begin
                main_valid_r <= 1'b0;
            end
        end else if (in_fire_s) begin
            skid_r       <= dec_s;
            skid_valid_r <= 1'b1;
        end
    end
`else
    // Combinational from out_ready so a departing entry can be replaced in the same cycle.
    assign in_ready = ~main_valid_r | out_ready;

    // Single payload register with replace-on-departure.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_r <= 1'b0;
            main_r       <= '0;
        end else if (flush) begin
            main_valid_r <= 1'b0;
        end else if (in_fire_s) begin
            main_valid_r <= 1'b1;
            main_r       <= dec_s;
        end else if (out_fire_s) begin
            main_valid_r <= 1'b0;
        end
    end
`endif

    assign out_valid       = main_valid_r;
    assign out_alu_control = main_r.alu_control;
    assign out_alu_src1    = main_r.src1;
    assign out_alu_src2    = main_r.src2;
    assign out_dest        = main_r.dest;
    assign out_ov_en       = main_r.ov_en;
    assign out_ri          = main_r.ri;

endmodule
